mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Sequencing front end for the 8-word × 8-bit `mem` array. It accepts single-word read/write requests on a valid/ready handshake and drives `mem`'s RW, one-hot-decoded address bits and data lines with safe setup/strobe/hold phasing. It selects and registers the addressed word from `mem`'s eight output buses and returns it on a one-cycle response pulse. It sits directly upstream of `mem`, between any requester and the array.

## Interface
- `WAIT_CYC`, default 1: cycles RW is held high for a write, or cycles allowed for read settle; legal range 1..15.
- `clk` input 1: the single clock; all logic is on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request.
- `req_we` input 1: 1 = write, 0 = read.
- `req_adr` input 3: word address 0..7.
- `req_wdata` input 8: write data.
- `rsp_valid` output 1: one-cycle completion pulse for both reads and writes.
- `rsp_we` output 1: echo of the `req_we` value of the completed request.
- `rsp_data` output 8: read data, or the written data for a write.
- `mem_rw` output 1: to `mem` RW; 1 = write, 0 = read.
- `mem_adr0`, `mem_adr1`, `mem_adr2` output 1 each: to `mem` address pins; `mem_adr0` = `req_adr[2]` (MSB) and `mem_adr2` = `req_adr[0]` (LSB).
- `mem_i0`..`mem_i7` output 1 each: to `mem` data inputs; `mem_iK` = `req_wdata[K]`.
- `mem_o0`..`mem_o7` input 8 each: word outputs of `mem`; `mem_oK` holds word K, with bit K of the word on bit K of the bus.

## Operation
- Request accepted when `req_valid && req_ready`. Address, data and we are latched into internal registers.
- `mem_adr*` and `mem_i*` are driven only from the latched registers. They never change while `mem_rw` = 1.
- State machine:
  - IDLE: `req_ready` = 1. On accept, go to SETUP.
  - SETUP: `mem_rw` = 0; address and data are stable. Write → STROBE. Read → SETTLE.
  - STROBE: `mem_rw` = 1 for WAIT_CYC cycles, then HOLD.
  - SETTLE: `mem_rw` = 0 for WAIT_CYC cycles. On the last cycle, `rsp_data` ← `mem_o[adr]`. Then go to HOLD.
  - HOLD: `mem_rw` = 0 and the address is still held. `rsp_valid` = 1 for exactly this cycle. Then go to IDLE.
- Read word selection is an 8:1 mux of `mem_o0..7` indexed by the latched address.
- `req_ready` = 0 in every state except IDLE. Requests presented while busy are not consumed; the requester holds them.
- Responses have no backpressure; the consumer must sample `rsp_valid` when it pulses.

## Timing
- For a request accepted in cycle T: SETUP in T+1, STROBE/SETTLE in T+2..T+1+WAIT_CYC, HOLD (`rsp_valid`) in T+2+WAIT_CYC. The block is back in IDLE at T+3+WAIT_CYC.
- With WAIT_CYC = 1: latency 3 cycles, and one request per 4 cycles.
- Back-to-back requests are not overlapped.
- Reset values: `req_ready` = 0 during `rst`, 1 in the cycle after reset (or after init, see Configuration). All of the following are 0: `rsp_valid`, `rsp_we`, `rsp_data`, `mem_rw`, `mem_adr0..2`, `mem_i0..7`.
- Reset mid-operation: `mem_rw` is forced to 0 in the reset cycle and the state returns to IDLE. No `rsp_valid` is issued for the aborted request. The contents of the word being written are undefined.
- `rst` takes priority over every other event.

## Configuration
- `MEM_CTRL_INIT_EN` defined: after reset, an INIT sequence writes 0x00 to addresses 0..7 in ascending order, using the SETUP/STROBE/HOLD phasing.
  - No `rsp_valid` is issued during INIT, and `req_ready` = 0 throughout.
  - IDLE is entered 8×(WAIT_CYC+2) cycles after reset deasserts.
  - A reset during INIT restarts it from address 0.
- Not defined: the block enters IDLE directly after reset, and `mem` contents are undefined until written.

## Structure
- Package `mem_ctrl_pkg` holds:
  - the state enum (IDLE, SETUP, STROBE, SETTLE, HOLD, INIT_SETUP, INIT_STROBE, INIT_HOLD);
  - `MEM_ADR_W` = 3, `MEM_DATA_W` = 8, `MEM_DEPTH` = 8.
- One sub-module, `mem_rd_sel`: a combinational 8:1 × 8-bit word selector from `mem_o0..7` by the 3-bit address.
- Everything else lives in `mem_ctrl`.

## Test plan
- Write 0xA5 to address 3, then read address 3 → `rsp_data` = 0xA5. Both `rsp_valid` pulses arrive 3 cycles after accept (WAIT_CYC = 1). During the write, `mem_adr0,1,2` = 0,1,1.
- Write 0x01 << k to each address k = 0..7, then read all eight → each word returns its own value, with no aliasing across words.
- Hold `req_valid` high continuously with 4 queued requests → accepts occur exactly 4 cycles apart. `req_ready` is low for 3 of every 4 cycles. `mem_adr*` and `mem_i*` are never seen changing while `mem_rw` = 1.
- WAIT_CYC = 3, write 0x3C → `mem_rw` is high for exactly 3 cycles, and `rsp_valid` arrives in T+5.
- Assert `rst` in the STROBE cycle of a write → `mem_rw` = 0 the next cycle, no `rsp_valid`, `req_ready` = 1 after release. A subsequent write/read of 0x77 to the same address returns 0x77.
- With `MEM_CTRL_INIT_EN` defined and WAIT_CYC = 1: `req_ready` stays low for 24 cycles after reset. Reads of all 8 addresses then return 0x00.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and sizes for the mem_ctrl front end.
//   state_t    - controller FSM states (request path + power-up INIT path)
//   MEM_ADR_W  - word address width of the mem array
//   MEM_DATA_W - word width of the mem array
//   MEM_DEPTH  - number of words in the mem array
package mem_ctrl_pkg;

    localparam int MEM_ADR_W  = 3;
    localparam int MEM_DATA_W = 8;
    localparam int MEM_DEPTH  = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        SETTLE,
        HOLD,
        INIT_SETUP,
        INIT_STROBE,
        INIT_HOLD
    } state_t;

endpackage

// File: rtl/mem_rd_sel.sv
// mem_rd_sel: combinational 8:1 word selector over the mem array outputs.
//   o0..o7 : word outputs of mem (word K on oK)
//   adr    : word address
//   word   : selected word
module mem_rd_sel
    import mem_ctrl_pkg::*;
(
    input  logic [MEM_DATA_W-1:0] o0,
    input  logic [MEM_DATA_W-1:0] o1,
    input  logic [MEM_DATA_W-1:0] o2,
    input  logic [MEM_DATA_W-1:0] o3,
    input  logic [MEM_DATA_W-1:0] o4,
    input  logic [MEM_DATA_W-1:0] o5,
    input  logic [MEM_DATA_W-1:0] o6,
    input  logic [MEM_DATA_W-1:0] o7,
    input  logic [MEM_ADR_W-1:0]  adr,
    output logic [MEM_DATA_W-1:0] word
);

    always_comb begin
        word = '0;
        case (adr)
            3'd0: word = o0;
            3'd1: word = o1;
            3'd2: word = o2;
            3'd3: word = o3;
            3'd4: word = o4;
            3'd5: word = o5;
            3'd6: word = o6;
            3'd7: word = o7;
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: sequencing front end for the 8x8 mem array.
// Accepts single-word read/write requests (valid/ready), drives mem's RW,
// address and data pins with setup/strobe/hold phasing, and returns a
// one-cycle response pulse carrying read data (or the written data).
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid/req_ready      - request handshake
//   req_we/req_adr/req_wdata - request: 1=write, word address, write data
//   rsp_valid/rsp_we/rsp_data- one-cycle completion pulse, echo of we, data
//   mem_rw                   - mem RW (1 = write)
//   mem_adr0..2              - mem address pins, mem_adr0 is the MSB
//   mem_i0..7                - mem data inputs, mem_iK = data bit K
//   mem_o0..7                - mem word outputs, word K on mem_oK
//
// Build option: define MEM_CTRL_INIT_EN to zero all words after reset
// before the first request is accepted.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [MEM_ADR_W-1:0]  req_adr,
    input  logic [MEM_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_we,
    output logic [MEM_DATA_W-1:0] rsp_data,
    output logic                  mem_rw,
    output logic                  mem_adr0,
    output logic                  mem_adr1,
    output logic                  mem_adr2,
    output logic                  mem_i0,
    output logic                  mem_i1,
    output logic                  mem_i2,
    output logic                  mem_i3,
    output logic                  mem_i4,
    output logic                  mem_i5,
    output logic                  mem_i6,
    output logic                  mem_i7,
    input  logic [MEM_DATA_W-1:0] mem_o0,
    input  logic [MEM_DATA_W-1:0] mem_o1,
    input  logic [MEM_DATA_W-1:0] mem_o2,
    input  logic [MEM_DATA_W-1:0] mem_o3,
    input  logic [MEM_DATA_W-1:0] mem_o4,
    input  logic [MEM_DATA_W-1:0] mem_o5,
    input  logic [MEM_DATA_W-1:0] mem_o6,
    input  logic [MEM_DATA_W-1:0] mem_o7
);

`ifdef MEM_CTRL_INIT_EN
    localparam state_t RST_STATE = INIT_SETUP;
    localparam logic   RST_READY = 1'b0;
`else
    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_READY = 1'b1;
`endif

    // Phase counter counts down to zero; loaded with WAIT_CYC-1 in SETUP.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);
    localparam logic [MEM_ADR_W-1:0] LAST_ADR = MEM_ADR_W'(MEM_DEPTH - 1);

    state_t                state;
    logic [3:0]            cnt;
    logic                  ready_q;
    logic                  we_q;
    logic [MEM_ADR_W-1:0]  adr_q;
    logic [MEM_DATA_W-1:0] wdata_q;
    logic [MEM_DATA_W-1:0] rd_word;
    logic                  accept;

    // Ready is gated by rst so it drops in the reset cycle itself and rises
    // in the first cycle after release.
    assign req_ready = ready_q & ~rst;
    assign accept    = req_valid & req_ready;

    // Pins come only from latched registers, which change only in IDLE /
    // INIT_HOLD while mem_rw is low.
    assign mem_adr0 = adr_q[2];
    assign mem_adr1 = adr_q[1];
    assign mem_adr2 = adr_q[0];
    assign mem_i0   = wdata_q[0];
    assign mem_i1   = wdata_q[1];
    assign mem_i2   = wdata_q[2];
    assign mem_i3   = wdata_q[3];
    assign mem_i4   = wdata_q[4];
    assign mem_i5   = wdata_q[5];
    assign mem_i6   = wdata_q[6];
    assign mem_i7   = wdata_q[7];

    mem_rd_sel u_rd_sel (
        .o0   (mem_o0),
        .o1   (mem_o1),
        .o2   (mem_o2),
        .o3   (mem_o3),
        .o4   (mem_o4),
        .o5   (mem_o5),
        .o6   (mem_o6),
        .o7   (mem_o7),
        .adr  (adr_q),
        .word (rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RST_STATE;
            ready_q   <= RST_READY;
            cnt       <= '0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_data  <= '0;
            mem_rw    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        adr_q   <= req_adr;
                        wdata_q <= req_wdata;
                        ready_q <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    cnt <= CNT_LOAD;
                    if (we_q) begin
                        mem_rw <= 1'b1;
                        state  <= STROBE;
                    end else begin
                        state  <= SETTLE;
                    end
                end
                STROBE: begin
                    if (cnt == 4'd0) begin
                        mem_rw    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_we    <= 1'b1;
                        rsp_data  <= wdata_q;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SETTLE: begin
                    // Capture the selected word on the last settle cycle.
                    if (cnt == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_we    <= 1'b0;
                        rsp_data  <= rd_word;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                INIT_SETUP: begin
                    cnt    <= CNT_LOAD;
                    mem_rw <= 1'b1;
                    state  <= INIT_STROBE;
                end
                INIT_STROBE: begin
                    if (cnt == 4'd0) begin
                        mem_rw <= 1'b0;
                        state  <= INIT_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                INIT_HOLD: begin
                    // wdata_q stays at its reset value of zero throughout INIT.
                    if (adr_q == LAST_ADR) begin
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        adr_q <= adr_q + 1'b1;
                        state <= INIT_SETUP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl. Two instances run side by
// side: g_dut[0] with WAIT_CYC=1 and g_dut[1] with WAIT_CYC=3, each driving
// its own behavioural mem array. Expected read data comes from a plain
// word array updated on every accepted write.
module tb_mem_ctrl;

    localparam int W0 = 1;
    localparam int W1 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       req_valid [2];
    logic       req_we    [2];
    logic [2:0] req_adr   [2];
    logic [7:0] req_wdata [2];
    logic       req_ready [2];
    logic       rsp_valid [2];
    logic       rsp_we    [2];
    logic [7:0] rsp_data  [2];
    logic       mrw       [2];
    logic [2:0] ma        [2];
    logic [7:0] mi        [2];
    logic [7:0] memq      [2][8];

    logic [7:0] refm [2][8];
    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_ctrl #(.WAIT_CYC(g == 0 ? W0 : W1)) dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_we(req_we[g]), .req_adr(req_adr[g]), .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_we(rsp_we[g]), .rsp_data(rsp_data[g]),
            .mem_rw(mrw[g]),
            .mem_adr0(ma[g][2]), .mem_adr1(ma[g][1]), .mem_adr2(ma[g][0]),
            .mem_i0(mi[g][0]), .mem_i1(mi[g][1]), .mem_i2(mi[g][2]), .mem_i3(mi[g][3]),
            .mem_i4(mi[g][4]), .mem_i5(mi[g][5]), .mem_i6(mi[g][6]), .mem_i7(mi[g][7]),
            .mem_o0(memq[g][0]), .mem_o1(memq[g][1]), .mem_o2(memq[g][2]), .mem_o3(memq[g][3]),
            .mem_o4(memq[g][4]), .mem_o5(memq[g][5]), .mem_o6(memq[g][6]), .mem_o7(memq[g][7])
        );
    end

    // Behavioural mem array: word written while RW is high at the clock edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (mrw[k] === 1'b1) memq[k][ma[k]] <= mi[k];
    end

    // Pin monitor: while RW is high, address/data must equal the previous
    // cycle's values; also counts RW-high cycles and records the write pins.
    logic [10:0] prev_pins [2];
    int          viol  [2] = '{0, 0};
    int          rwcnt [2] = '{0, 0};
    logic [2:0]  lastwa [2];
    logic [7:0]  lastwd [2];
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mrw[k] === 1'b1) begin
                if ({ma[k], mi[k]} !== prev_pins[k]) viol[k] <= viol[k] + 1;
                rwcnt[k]  <= rwcnt[k] + 1;
                lastwa[k] <= ma[k];
                lastwd[k] <= mi[k];
            end
            prev_pins[k] <= {ma[k], mi[k]};
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic int wcyc(input int k);
        return (k == 0) ? W0 : W1;
    endfunction

    // One request on instance k; lat = negedges from accept edge to rsp_valid.
    task automatic op(input int k, input logic we, input logic [2:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic rwe, output int lat);
        int n = 0;
        rd = '0; rwe = 1'b0; lat = 0;
        @(negedge clk);
        req_valid[k] = 1'b1; req_we[k] = we; req_adr[k] = a; req_wdata[k] = d;
        while (!req_ready[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk("accept_timeout", 1, 0);
            req_valid[k] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rsp_valid[k]) begin
                lat = i; rd = rsp_data[k]; rwe = rsp_we[k];
                break;
            end
        end
        @(negedge clk);
        chk("rsp_pulse_one_cycle", rsp_valid[k], 0);
    endtask

    // Request checked against the reference word array.
    task automatic run(input int k, input logic we, input logic [2:0] a, input logic [7:0] d,
                       input string tag);
        logic [7:0] rd, exp;
        logic       rwe;
        int         lat;
        exp = we ? d : refm[k][a];
        op(k, we, a, d, rd, rwe, lat);
        chk({tag, "_latency"}, lat, wcyc(k) + 2);
        chk({tag, "_we"}, rwe, we);
        chk({tag, "_data"}, rd, exp);
        if (we) refm[k][a] = d;
    endtask

    typedef struct {
        logic       we;
        logic [2:0] adr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [18];

    initial begin
        logic [7:0] rd;
        logic       rwe;
        int         lat, base, cnt_rv;
        int         acc [4];
        logic [7:0] td  [4];
        int         ng, lo, nacc;

        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; req_we[k] = 1'b0; req_adr[k] = '0; req_wdata[k] = '0;
            for (int a = 0; a < 8; a++) refm[k][a] = 8'h00;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_ready", req_ready[k], 0);
            chk("reset_outputs", {rsp_valid[k], rsp_we[k], rsp_data[k], mrw[k], ma[k], mi[k]}, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
`ifdef MEM_CTRL_INIT_EN
        begin
            int first [2] = '{0, 0};
            for (int c = 1; c <= 60; c++) begin
                @(negedge clk);
                for (int k = 0; k < 2; k++)
                    if (first[k] == 0 && req_ready[k]) first[k] = c;
            end
            for (int k = 0; k < 2; k++)
                chk("init_ready_low_cycles", first[k] - 1, 8 * (wcyc(k) + 2));
            for (int k = 0; k < 2; k++)
                for (int a = 0; a < 8; a++)
                    run(k, 1'b0, 3'(a), 8'h00, "init_read_zero");
        end
`else
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("ready_after_reset", req_ready[k], 1);
`endif

        // Table: A5 to address 3 and back, then walking ones in every word.
        tbl[0] = '{1'b1, 3'd3, 8'hA5, 8'hA5};
        tbl[1] = '{1'b0, 3'd3, 8'h00, 8'hA5};
        for (int k = 0; k < 8; k++) begin
            tbl[2 + k]  = '{1'b1, 3'(k), 8'(1 << k), 8'(1 << k)};
            tbl[10 + k] = '{1'b0, 3'(k), 8'h00, 8'(1 << k)};
        end
        for (int i = 0; i < 18; i++) begin
            op(0, tbl[i].we, tbl[i].adr, tbl[i].data, rd, rwe, lat);
            chk($sformatf("tbl%0d_latency", i), lat, 3);
            chk($sformatf("tbl%0d_we", i), rwe, tbl[i].we);
            chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp);
            if (i == 0) begin
                chk("tbl0_adr_pins_011", lastwa[0], 3'b011);
                chk("tbl0_data_pins", lastwd[0], 8'hA5);
            end
            if (tbl[i].we) refm[0][tbl[i].adr] = tbl[i].data;
        end

        // WAIT_CYC=3: RW high exactly 3 cycles, response at T+5.
        base = rwcnt[1];
        run(1, 1'b1, 3'd2, 8'h3C, "w3_write");
        chk("w3_rw_high_cycles", rwcnt[1] - base, 3);
        run(1, 1'b0, 3'd2, 8'h00, "w3_read");
        for (int a = 0; a < 8; a++) run(1, 1'b1, 3'(a), 8'($urandom), "w3_fill");

        // Continuous valid with four queued writes: accepts 4 cycles apart.
        for (int i = 0; i < 4; i++) td[i] = 8'($urandom);
        ng = 0; lo = 0; nacc = 0;
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_adr[0] = 3'd0; req_wdata[0] = td[0];
        while (nacc < 4 && ng < 80) begin
            if (req_ready[0]) begin
                acc[nacc] = ng;
                refm[0][nacc] = td[nacc];
                nacc++;
                @(posedge clk);
                #1;
                if (nacc < 4) begin
                    req_adr[0] = 3'(nacc); req_wdata[0] = td[nacc];
                end else begin
                    req_valid[0] = 1'b0;
                end
            end else begin
                lo++;
            end
            @(negedge clk);
            ng++;
        end
        chk("tp_accepts", nacc, 4);
        if (nacc == 4) begin
            for (int i = 1; i < 4; i++) chk($sformatf("tp_gap%0d", i), acc[i] - acc[i-1], 4);
            chk("tp_ready_low_cycles", lo, 9);
        end
        repeat (5) @(negedge clk);

        // Randomized traffic on both instances against the reference array.
        for (int i = 0; i < 30; i++)
            run($urandom_range(0, 1), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                8'($urandom), $sformatf("rnd%0d", i));

        // Reset in the STROBE cycle of a write.
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_adr[0] = 3'd5; req_wdata[0] = 8'h55;
        chk("abort_ready_before", req_ready[0], 1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_strobe", mrw[0], 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rw_low", mrw[0], 0);
        chk("abort_no_rsp", rsp_valid[0], 0);
        chk("abort_ready_in_reset", req_ready[0], 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cnt_rv = 0;
        @(negedge clk);
`ifdef MEM_CTRL_INIT_EN
        chk("abort_ready_after", req_ready[0], 0);
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 8; a++) refm[k][a] = 8'h00;
`else
        chk("abort_ready_after", req_ready[0], 1);
`endif
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid[0] || rsp_valid[1]) cnt_rv++;
            @(negedge clk);
        end
        chk("abort_no_rsp_after", cnt_rv, 0);
        run(0, 1'b1, 3'd5, 8'h77, "post_abort_write");
        run(0, 1'b0, 3'd5, 8'h00, "post_abort_read");
        run(1, 1'b0, 3'd2, 8'h00, "post_abort_other");

        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("pins_stable_while_rw", viol[k], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
